ncl_rx_bridge: RTL and testbench

NCL_RX_BRIDGE -- requirements
Module: ncl_rx_bridge

---
 rtl/ncl_pkg.sv | 22 ++
 rtl/ncl_dr_sync.sv | 33 +++
 rtl/ncl_rx_bridge.sv | 142 ++++++++++++++
 tb/tb_ncl_rx_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_pkg.sv
// Shared types and constants for the NCL receive bridge.
// Holds the dual-rail bit type, the rail-pair encodings and the bridge FSM states.
package ncl_pkg;

  // One NCL bit as a rail pair; the packed order puts rail1 in the upper bit.
  typedef struct packed {
    logic rail1;
    logic rail0;
  } dual_rail_logic;

  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_ZERO    = 2'b01;
  localparam logic [1:0] DR_ONE     = 2'b10;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    WAIT_NULL,
    WAIT_DATA,
    HOLD
  } rx_state_e;

endpackage

// File: rtl/ncl_dr_sync.sv
// Two-flop synchronizer applied to every rail of a dual-rail word.
// Ports:
//   clk   - destination clock (rising edge)
//   rst_n - asynchronous active-low reset, clears both stages to 0
//   din   - asynchronous dual-rail word
//   dout  - synchronized dual-rail word (second stage)
module ncl_dr_sync
  import ncl_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  dual_rail_logic [WIDTH-1:0] din,
  output dual_rail_logic [WIDTH-1:0] dout
);

  dual_rail_logic [WIDTH-1:0] meta_q;
  dual_rail_logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/ncl_rx_bridge.sv
// Bridge from an asynchronous NCL (dual-rail, NULL/DATA handshake) producer to a
// synchronous valid/ready consumer. The word is synchronized, must be complete and
// stable for SETTLE samples, then its rail1 values are presented as out_data.
// Ports:
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   din        - dual-rail result word from the producer
//   Ki         - 1 = request DATA, 0 = request NULL
//   out_valid  - captured result available
//   out_ready  - consumer accepts the result
//   out_data   - binary result (rail1 of the captured word)
//   err        - sticky illegal-encoding flag
// Build option: define NCL_RX_ILLEGAL_CHECK_EN to make err latch any 2'b11 rail pair;
// otherwise err is tied to 0.
module ncl_rx_bridge
  import ncl_pkg::*;
#(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  dual_rail_logic [WIDTH-1:0] din,
  output logic                       Ki,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       err
);

  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  dual_rail_logic [WIDTH-1:0] sync_word;
  dual_rail_logic [WIDTH-1:0] prev_q;
  rx_state_e                  state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [WIDTH-1:0]           data_q;
  logic [1:0]                 prime_q;
  logic [WIDTH-1:0]           rail1;
  logic                       complete;
  logic                       all_null;
  logic                       capture;
`ifdef NCL_RX_ILLEGAL_CHECK_EN
  logic                       any_illegal;
  logic                       err_q;
`endif

  ncl_dr_sync #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (sync_word)
  );

  // Classify the synchronized word.
  always_comb begin
    complete = 1'b1;
    all_null = 1'b1;
    rail1    = '0;
`ifdef NCL_RX_ILLEGAL_CHECK_EN
    any_illegal = 1'b0;
`endif
    for (int i = 0; i < int'(WIDTH); i++) begin
      rail1[i] = sync_word[i].rail1;
      case ({sync_word[i].rail1, sync_word[i].rail0})
        DR_NULL:         complete = 1'b0;
        DR_ZERO, DR_ONE: all_null = 1'b0;
        default: begin
          complete = 1'b0;
          all_null = 1'b0;
`ifdef NCL_RX_ILLEGAL_CHECK_EN
          any_illegal = 1'b1;
`endif
        end
      endcase
    end
  end

  // The synchronizer resets to zeros, which decode as all-NULL. prime_q[1] only
  // goes high once the pipeline holds a genuine post-reset sample, so a reset
  // value can never fake the NULL phase and request DATA early.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    capture = 1'b0;
    unique case (state_q)
      WAIT_NULL: begin
        if (prime_q[1] && all_null) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (complete) begin
          // A newly complete word is its own first identical sample.
          cnt_d = (sync_word == prev_q) ? cnt_q + 4'd1 : 4'd1;
          if (cnt_d == SettleCnt) begin
            capture = 1'b1;
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = WAIT_NULL;
      end
      default: state_d = WAIT_NULL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_NULL;
      cnt_q   <= '0;
      prev_q  <= '0;
      data_q  <= '0;
      prime_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= sync_word;
      prime_q <= {prime_q[0], 1'b1};
      if (capture) data_q <= rail1;
    end
  end

`ifdef NCL_RX_ILLEGAL_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (any_illegal) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign Ki        = (state_q != WAIT_NULL);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;

endmodule

// File: tb/tb_ncl_rx_bridge.sv
// Self-checking bench for ncl_rx_bridge: scoreboard of expected words popped on each
// out_valid/out_ready handshake, plus directed checks of Ki, timing, err and reset.
module tb_ncl_rx_bridge;
  import ncl_pkg::*;

  localparam int unsigned WIDTH = 6;

  logic                       clk = 1'b0;
  logic                       rst_n;
  dual_rail_logic [WIDTH-1:0] din;
  logic                       ki;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic                       err;

  int               total = 0;
  int               bad   = 0;
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] sb_exp;
  logic             err_exp;

  ncl_rx_bridge #(
    .WIDTH (WIDTH),
    .SETTLE(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .Ki       (ki),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] v);
    logic [2*WIDTH-1:0] r;
    for (int i = 0; i < int'(WIDTH); i++) r[2*i +: 2] = v[i] ? DR_ONE : DR_ZERO;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic wait_ki(output int n);
    n = 0;
    while (!ki && n < 20) begin
      step();
      n++;
    end
  endtask

  // Handshake happens on the next rising edge; compare against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 32'(out_valid), 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_data", 32'(out_data), 32'(sb_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int                 n;
    int                 hits;
    int                 ki_hits;
    logic [2*WIDTH-1:0] tmp;
    logic [WIDTH-1:0]   v;

`ifdef NCL_RX_ILLEGAL_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif

    // Reset state.
    rst_n     = 1'b0;
    din       = '0;
    out_ready = 1'b1;
    #1;
    check("rst_ki", 32'(ki), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Basic transfer of 14.
    wait_ki(n);
    check("basic_ki_up", 32'(ki), 32'd1);
    din = enc(6'd14);
    sb_q.push_back(6'd14);
    wait_valid(n);
    check("basic_latency", 32'(n), 32'd4);
    check("basic_data", 32'(out_data), 32'd14);
    step();
    check("basic_valid_1cyc", 32'(out_valid), 32'd0);
    check("basic_ki_down", 32'(ki), 32'd0);
    din = '0;
    wait_ki(n);
    check("basic_null_ki", 32'(n), 32'd3);

    // Skewed arrival of 35, one bit per clock.
    v    = 6'd35;
    tmp  = '0;
    hits = 0;
    for (int b = 0; b < int'(WIDTH); b++) begin
      if (b > 0) step();
      hits += int'(out_valid);
      tmp[2*b +: 2] = v[b] ? DR_ONE : DR_ZERO;
      din = tmp;
    end
    sb_q.push_back(6'd35);
    check("skew_no_early", 32'(hits), 32'd0);
    wait_valid(n);
    check("skew_latency", 32'(n), 32'd4);
    step();
    din = '0;
    wait_ki(n);
    check("skew_null_ki", 32'(ki), 32'd1);

    // Backpressure: hold 14 for 10 cycles while din wanders.
    out_ready = 1'b0;
    din = enc(6'd14);
    sb_q.push_back(6'd14);
    wait_valid(n);
    check("bp_latency", 32'(n), 32'd4);
    for (int c = 0; c < 10; c++) begin
      if (c == 2) din = '0;
      if (c == 6) din = enc(6'd9);
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'd14);
      check("bp_ki", 32'(ki), 32'd1);
    end
    out_ready = 1'b1;
    step();
    check("bp_released", 32'(out_valid), 32'd0);
    check("bp_ki_down", 32'(ki), 32'd0);
    check("bp_data_kept", 32'(out_data), 32'd14);
    step();
    step();
    step();
    check("bp_ki_wait_null", 32'(ki), 32'd0);
    din = '0;
    wait_ki(n);
    check("bp_null_ki", 32'(ki), 32'd1);

    // Illegal encoding on bit 3.
    tmp = enc(6'd14);
    tmp[7:6] = DR_ILLEGAL;
    din  = tmp;
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      hits += int'(out_valid);
    end
    check("ill_no_capture", 32'(hits), 32'd0);
    check("ill_err", 32'(err), 32'(err_exp));
    din = '0;
    for (int c = 0; c < 5; c++) step();
    check("ill_err_sticky", 32'(err), 32'(err_exp));
    check("ill_ki", 32'(ki), 32'd1);

    // Reset during the settle count.
    din = enc(6'd21);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ki", 32'(ki), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    step();
    rst_n   = 1'b1;
    hits    = 0;
    ki_hits = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      hits    += int'(out_valid);
      ki_hits += int'(ki);
    end
    check("post_rst_no_valid", 32'(hits), 32'd0);
    check("post_rst_no_ki", 32'(ki_hits), 32'd0);
    din = '0;
    wait_ki(n);
    check("post_rst_null_ki", 32'(n), 32'd3);
    din = enc(6'd42);
    sb_q.push_back(6'd42);
    wait_valid(n);
    check("post_rst_latency", 32'(n), 32'd4);
    step();
    step();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
